// File: rtl/execute_unit.sv
// -----------------------------------------------------------------------------
// execute_unit
//   Execute stage: 16-bit ALU, branch resolution and a multi-cycle restoring
//   unsigned divider. A divide holds the decode/execute register through the
//   combinational stall output. Every stalled edge loads a bubble into the
//   output registers.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   J, B, Mem, Store, Div,   decoded control flags
//   Im, MWE, Mux, RWE
//   Op[3:0]                  ALU op / divide result select (Op[0])
//   DATA_A, DATA_B [15:0]    source operands
//   A_Reg, B_Reg, C_Reg[7:0] destination, source and immediate fields
//   stall                    hold request to the decode/execute register
//   Res_o, Store_Data_o,     registered results and forwarded fields
//   Dest_o, MWE_o, RWE_o,
//   Mux_o, Mem_o,
//   Br_Taken_o, Br_Target_o
//
// Divider FSM
//   state | meaning
//   IDLE  | single-cycle instructions; Div=1 latches operands and stalls
//   BUSY  | one shift-subtract step per cycle, 16 steps, stalled
//   DONE  | quotient/remainder ready, stall released, back to IDLE
// -----------------------------------------------------------------------------
module execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        J,
    input  logic        B,
    input  logic        Mem,
    input  logic        Store,
    input  logic        Div,
    input  logic        Im,
    input  logic        MWE,
    input  logic        Mux,
    input  logic        RWE,
    input  logic [3:0]  Op,
    input  logic [15:0] DATA_A,
    input  logic [15:0] DATA_B,
    input  logic [7:0]  A_Reg,
    input  logic [7:0]  B_Reg,
    input  logic [7:0]  C_Reg,
    output logic        stall,
    output logic [15:0] Res_o,
    output logic [15:0] Store_Data_o,
    output logic [7:0]  Dest_o,
    output logic        MWE_o,
    output logic        RWE_o,
    output logic        Mux_o,
    output logic        Mem_o,
    output logic        Br_Taken_o,
    output logic [15:0] Br_Target_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [15:0] quo;
    logic [15:0] rem;
    logic [15:0] dvsr;

    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] alu;
    logic [15:0] result;
    logic [16:0] shifted;
    logic [16:0] diff;
    logic        ge;

    // Store and B_Reg are decoded upstream; nothing in this stage uses them.
    logic unused_ok;
    assign unused_ok = Store ^ (^B_Reg);

    assign x = DATA_A;
    assign y = Im ? {{8{C_Reg[7]}}, C_Reg} : DATA_B;

    always_comb begin
        alu = x;
        case (Op)
            4'd0:    alu = x + y;
            4'd1:    alu = x - y;
            4'd2:    alu = x & y;
            4'd3:    alu = x | y;
            4'd4:    alu = x ^ y;
            4'd5:    alu = ~x;
            4'd6:    alu = x << y[3:0];
            4'd7:    alu = x >> y[3:0];
            4'd8:    alu = $signed(x) >>> y[3:0];
            4'd9:    alu = {15'd0, ($signed(x) < $signed(y))};
            4'd10:   alu = x * y;
            4'd11:   alu = y;
            default: alu = x;
        endcase
    end

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. A zero divisor always "fits",
    // which yields quotient FFFF and remainder equal to the dividend.
    assign shifted = {rem, quo[15]};
    assign diff    = shifted - {1'b0, dvsr};
    assign ge      = (shifted >= {1'b0, dvsr});

    assign result = (state == DONE) ? (Op[0] ? rem : quo) : alu;

    // Gated by rst so the hold request drops the moment reset asserts.
    assign stall = !rst && (((state == IDLE) && Div) || (state == BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 5'd0;
            quo   <= 16'd0;
            rem   <= 16'd0;
            dvsr  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Div) begin
                        quo   <= DATA_A;
                        rem   <= 16'd0;
                        dvsr  <= DATA_B;
                        count <= 5'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    quo   <= {quo[14:0], ge};
                    rem   <= ge ? diff[15:0] : shifted[15:0];
                    count <= count + 5'd1;
                    if (count == 5'd15) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    count <= 5'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Res_o        <= 16'd0;
            Store_Data_o <= 16'd0;
            Dest_o       <= 8'd0;
            MWE_o        <= 1'b0;
            RWE_o        <= 1'b0;
            Mux_o        <= 1'b0;
            Mem_o        <= 1'b0;
            Br_Taken_o   <= 1'b0;
            Br_Target_o  <= 16'd0;
        end else if (stall) begin
            MWE_o      <= 1'b0;
            RWE_o      <= 1'b0;
            Br_Taken_o <= 1'b0;
        end else begin
            Res_o        <= result;
            Store_Data_o <= DATA_B;
            Dest_o       <= A_Reg;
            MWE_o        <= MWE;
            RWE_o        <= RWE;
            Mux_o        <= Mux;
            Mem_o        <= Mem;
            Br_Taken_o   <= J | (B & (DATA_A == 16'd0));
            Br_Target_o  <= DATA_B;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        J, B, Mem, Store, Div, Im, MWE, Mux, RWE;
    logic [3:0]  Op;
    logic [15:0] DATA_A, DATA_B;
    logic [7:0]  A_Reg, B_Reg, C_Reg;
    logic        stall;
    logic [15:0] Res_o, Store_Data_o, Br_Target_o;
    logic [7:0]  Dest_o;
    logic        MWE_o, RWE_o, Mux_o, Mem_o, Br_Taken_o;

    int passed = 0;
    int total  = 0;

    execute_unit dut (
        .clk(clk), .rst(rst),
        .J(J), .B(B), .Mem(Mem), .Store(Store), .Div(Div), .Im(Im),
        .MWE(MWE), .Mux(Mux), .RWE(RWE), .Op(Op),
        .DATA_A(DATA_A), .DATA_B(DATA_B),
        .A_Reg(A_Reg), .B_Reg(B_Reg), .C_Reg(C_Reg),
        .stall(stall), .Res_o(Res_o), .Store_Data_o(Store_Data_o),
        .Dest_o(Dest_o), .MWE_o(MWE_o), .RWE_o(RWE_o), .Mux_o(Mux_o),
        .Mem_o(Mem_o), .Br_Taken_o(Br_Taken_o), .Br_Target_o(Br_Target_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic im, input logic [7:0] c,
                         input logic [15:0] exp);
        Div = 1'b0; J = 1'b0; B = 1'b0;
        Op = op; DATA_A = a; DATA_B = b; Im = im; C_Reg = c;
        #1;
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        tick();
        check(tag, {16'd0, Res_o}, {16'd0, exp});
    endtask

    // Drives a divide and leaves Div asserted; Im=1 with a nonzero immediate
    // shows the divisor comes from DATA_B regardless.
    task automatic do_div(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        int cnt;
        Div = 1'b1; Op = op; DATA_A = a; DATA_B = b;
        Im = 1'b1; C_Reg = 8'h01; RWE = 1'b1; MWE = 1'b1; A_Reg = 8'h0A;
        J = 1'b0; B = 1'b0;
        #1;
        cnt = 0;
        while (stall && cnt < 40) begin
            cnt++;
            tick();
            if (cnt == 1) begin
                check({tag, "_rwe_bubble"}, {31'd0, RWE_o}, 32'd0);
                check({tag, "_mwe_bubble"}, {31'd0, MWE_o}, 32'd0);
            end
        end
        check({tag, "_stall_cycles"}, cnt, 32'd17);
        tick();
        check(tag, {16'd0, Res_o}, {16'd0, exp});
        check({tag, "_rwe_done"}, {31'd0, RWE_o}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        J = 0; B = 0; Mem = 0; Store = 0; Div = 1'b1; Im = 0; MWE = 0; Mux = 0; RWE = 0;
        Op = 4'd0; DATA_A = 16'd0; DATA_B = 16'd0; A_Reg = 8'd0; B_Reg = 8'd0; C_Reg = 8'd0;
        #12;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_res", {16'd0, Res_o}, 32'd0);
        check("rst_brtaken", {31'd0, Br_Taken_o}, 32'd0);
        Div = 1'b0;
        tick();
        rst = 1'b0;

        // ADD with overflow wrap
        RWE = 1'b1; MWE = 1'b1; Mux = 1'b1; Mem = 1'b1; A_Reg = 8'h05;
        do_op("add", 4'd0, 16'h7FFF, 16'h0001, 1'b0, 8'h00, 16'h8000);
        check("add_rwe", {31'd0, RWE_o}, 32'd1);
        check("add_dest", {24'd0, Dest_o}, 32'h05);
        check("add_store", {16'd0, Store_Data_o}, 32'h0001);
        check("add_mux", {31'd0, Mux_o}, 32'd1);
        check("add_mem", {31'd0, Mem_o}, 32'd1);
        MWE = 1'b0; Mux = 1'b0; Mem = 1'b0;

        do_op("sub_imm", 4'd1, 16'h0003, 16'h5555, 1'b1, 8'hFF, 16'h0004);
        do_op("slt",  4'd9,  16'hFFFF, 16'h0001, 1'b0, 8'h00, 16'h0001);
        do_op("slt0", 4'd9,  16'h0001, 16'hFFFF, 1'b0, 8'h00, 16'h0000);
        do_op("and",  4'd2,  16'hF0F0, 16'h0FF0, 1'b0, 8'h00, 16'h00F0);
        do_op("or",   4'd3,  16'hF0F0, 16'h0FF0, 1'b0, 8'h00, 16'hFFF0);
        do_op("xor",  4'd4,  16'hF0F0, 16'h0FF0, 1'b0, 8'h00, 16'hFF00);
        do_op("not",  4'd5,  16'hF0F0, 16'h0FF0, 1'b0, 8'h00, 16'h0F0F);
        do_op("shl",  4'd6,  16'h8001, 16'h0004, 1'b0, 8'h00, 16'h0010);
        do_op("shr",  4'd7,  16'h8001, 16'h0004, 1'b0, 8'h00, 16'h0800);
        do_op("sra",  4'd8,  16'h8001, 16'h0004, 1'b0, 8'h00, 16'hF800);
        do_op("mul",  4'd10, 16'h0100, 16'h0123, 1'b0, 8'h00, 16'h2300);
        do_op("passy", 4'd11, 16'h1111, 16'h2222, 1'b1, 8'h80, 16'hFF80);
        do_op("passx", 4'd13, 16'h1111, 16'h2222, 1'b0, 8'h00, 16'h1111);

        // Divides: quotient, then back-to-back remainder from the next IDLE
        do_div("div_q", 4'd0, 16'd1000, 16'd7, 16'd142);
        do_div("div_r", 4'd1, 16'd1000, 16'd7, 16'd6);
        do_div("div0_q", 4'd0, 16'h1234, 16'h0000, 16'hFFFF);
        do_div("div0_r", 4'd1, 16'h1234, 16'h0000, 16'h1234);
        Div = 1'b0;
        tick();

        // Reset in the middle of a divide (counter = 8)
        Div = 1'b1; Op = 4'd0; DATA_A = 16'd1000; DATA_B = 16'd7; A_Reg = 8'h0A;
        for (int i = 0; i < 9; i++) tick();
        check("midrst_stall_pre", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_res", {16'd0, Res_o}, 32'd0);
        check("midrst_dest", {24'd0, Dest_o}, 32'd0);
        check("midrst_store", {16'd0, Store_Data_o}, 32'd0);
        tick();
        rst = 1'b0;
        do_div("div_after_rst", 4'd0, 16'd1000, 16'd7, 16'd142);
        Div = 1'b0;

        // Branches
        Im = 1'b0; Op = 4'd0;
        B = 1'b1; J = 1'b0; DATA_A = 16'h0000; DATA_B = 16'h0040;
        tick();
        check("br_taken", {31'd0, Br_Taken_o}, 32'd1);
        check("br_target", {16'd0, Br_Target_o}, 32'h0040);
        DATA_A = 16'h0001;
        tick();
        check("br_not_taken", {31'd0, Br_Taken_o}, 32'd0);
        J = 1'b1; B = 1'b0; DATA_A = 16'h0005; DATA_B = 16'h0100;
        tick();
        check("jump_taken", {31'd0, Br_Taken_o}, 32'd1);
        check("jump_target", {16'd0, Br_Target_o}, 32'h0100);
        J = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide decoded-instruction inputs: J, B, Mem, Store, Div, Im, MWE, Mux, RWE  in  1 each  control flags.
REQ-004 SHALL provide: Op  in  4  ALU/divide operation select.
REQ-005 SHALL provide: DATA_A, DATA_B  in  16 each  source operands.
REQ-006 SHALL provide: A_Reg, B_Reg, C_Reg  in  8 each  destination, source and immediate fields.
REQ-007 SHALL provide: stall  out  1  combinational hold request to the decode/execute pipeline register.
REQ-008 SHALL provide registered outputs: Res_o 16 (result), Store_Data_o 16, Dest_o 8, MWE_o, RWE_o, Mux_o, Mem_o, Br_Taken_o (1 each), Br_Target_o 16.

Function
REQ-009 SHALL select operand Y = {{8{C_Reg[7]}},C_Reg} when Im=1, else Y = DATA_B; operand X = DATA_A.
REQ-010 SHALL compute, for Div=0, per Op: 0 X+Y, 1 X-Y, 2 X&Y, 3 X|Y, 4 X^Y, 5 ~X, 6 X<<Y[3:0], 7 X>>Y[3:0] logical, 8 arithmetic X>>>Y[3:0], 9 signed X<Y ? 1:0, 10 low 16 bits of X*Y, 11 Y, 12-15 X.
REQ-011 SHALL discard carries/overflow; all results wrap modulo 2^16.
REQ-012 SHALL, on each non-stalled edge, load Res_o=result, Store_Data_o=DATA_B, Dest_o=A_Reg, and copy MWE, RWE, Mux, Mem into their _o registers.
REQ-013 SHALL set Br_Taken_o = J | (B & (DATA_A==0)) and Br_Target_o = DATA_B on each non-stalled edge.
REQ-014 SHALL implement the divider FSM with states IDLE, BUSY, DONE and a 5-bit iteration counter.
REQ-015 SHALL, in IDLE with Div=1, assert stall combinationally; at the edge latch X (dividend) and DATA_B (divisor; Im ignored for Div) and enter BUSY with counter=0.
REQ-016 SHALL, in BUSY, perform one restoring unsigned shift-subtract step per cycle with stall=1, moving to DONE after step 16 (counter 15 -> DONE).
REQ-017 SHALL, in DONE, drive stall=0; the edge loads Res_o = quotient (Op[0]=0) or remainder (Op[0]=1) plus REQ-012/013 fields, then returns to IDLE.
REQ-018 SHALL yield 18 cycles in execute per divide (stall high for 17 consecutive cycles); non-divide instructions take 1 cycle, stall=0.
REQ-019 SHALL, on every edge where stall=1, load a bubble: MWE_o=RWE_o=Br_Taken_o=0; other output registers hold.
REQ-020 SHALL, for divisor 0, run the full 16 steps and return quotient 16'hFFFF, remainder = dividend.
REQ-021 SHALL ignore Div-input changes while BUSY or DONE; operands used are those latched in IDLE.
REQ-022 SHALL not start a new divide from DONE; a back-to-back Div instruction is accepted only in the following IDLE cycle.

Reset
REQ-023 SHALL, on rst=1, immediately force IDLE, counter 0, stall 0, and clear every output register to 0, including mid-division (partial result discarded).
REQ-024 SHALL, after rst deasserts, accept the instruction present at the first posedge.

Verification
REQ-025 ADD, Im=0, DATA_A=16'h7FFF, DATA_B=16'h0001, RWE=1, A_Reg=8'h05 -> next edge Res_o=16'h8000, RWE_o=1, Dest_o=8'h05, stall=0.
REQ-026 SUB, Im=1, DATA_A=16'h0003, C_Reg=8'hFF -> Res_o=16'h0004; Op=9, DATA_A=16'hFFFF, DATA_B=16'h0001 -> Res_o=16'h0001.
REQ-027 Div=1, Op=0, DATA_A=16'd1000, DATA_B=16'd7 -> stall high 17 cycles, RWE_o=0 during stall, then Res_o=16'd142; repeat with Op=1 -> Res_o=16'd6.
REQ-028 Div=1, DATA_B=0, DATA_A=16'h1234 -> after 18 cycles Res_o=16'hFFFF (Op=0), 16'h1234 (Op=1).
REQ-029 rst pulse at BUSY counter=8 -> stall drops immediately, all outputs 0; the next Div completes in full 18 cycles with correct result.
REQ-030 B=1, DATA_A=0, DATA_B=16'h0040 -> Br_Taken_o=1, Br_Target_o=16'h0040; DATA_A=1 -> Br_Taken_o=0; J=1 -> Br_Taken_o=1 regardless.
